// File: rtl/dm_store_unit_if.sv
// Pipeline <-> data-memory bus: address, store data, access control, load return.
// master = MEM-stage pipeline side, slave = dm_store_unit.
interface dm_store_unit_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_signed;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  modport master (
    output pc,
    output addr,
    output wdata,
    output mem_write,
    output size,
    output load_signed,
    input  rdata,
    input  busy,
    input  addr_err
  );

  modport slave (
    input  pc,
    input  addr,
    input  wdata,
    input  mem_write,
    input  size,
    input  load_signed,
    output rdata,
    output busy,
    output addr_err
  );
endinterface

// File: rtl/dm_store_unit.sv
// MEM-stage data memory: word RAM, lane-merged stores, extended loads, post-reset clear.
// Ports: clk, reset (sync, active-high), bus (dm_store_unit_if.slave). Macro DM_TRACE_EN adds a store trace.
module dm_store_unit #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  dm_store_unit_if.slave  bus
);

  if (DEPTH < 2) begin : g_chk_depth
    $error("DEPTH must be >= 2");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_chk_aw
    $error("2**ADDR_W must be >= DEPTH");
  end

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U = 32'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]       mem_q [DEPTH];

  logic              ready;
  logic              is_word, is_half, is_byte;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       idx_ext;
  logic              idx_ok, hi_ok, misalign, err;
  logic [31:0]       rd_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       merged;
  logic [31:0]       rdata_c;
  logic              commit;

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = READY;
          clr_ptr_d = '0;
        end
      end
      READY: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign ready = (state_q == READY);

  // Access decode; size 11 falls through to word
  always_comb begin
    is_word = 1'b0;
    is_half = 1'b0;
    is_byte = 1'b0;
    unique case (1'b1)
      (bus.size == 2'b01): is_half = 1'b1;
      (bus.size == 2'b10): is_byte = 1'b1;
      default:             is_word = 1'b1;
    endcase
  end

  assign lane     = bus.addr[1:0];
  assign idx      = bus.addr[ADDR_W+1:2];
  assign idx_ext  = {{(32-ADDR_W){1'b0}}, idx};
  assign idx_ok   = (idx_ext < DEPTH_U);
  assign hi_ok    = (bus.addr[31:ADDR_W+2] == '0);
  assign misalign = (is_half & lane[0]) | (is_word & (|lane));
  assign err      = ready & (misalign | ~idx_ok | ~hi_ok);

  // Guarded so an out-of-range index never touches the array
  assign rd_word = idx_ok ? mem_q[idx] : '0;
  assign byte_v  = rd_word[{lane, 3'b000} +: 8];
  assign half_v  = rd_word[{lane[1], 4'b0000} +: 16];

  // Store lane merge against the current word
  always_comb begin
    merged = rd_word;
    unique case (1'b1)
      is_byte: merged[{lane, 3'b000} +: 8]     = bus.wdata[7:0];
      is_half: merged[{lane[1], 4'b0000} +: 16] = bus.wdata[15:0];
      default: merged = bus.wdata;
    endcase
  end

  // Load extraction and extension
  always_comb begin
    rdata_c = '0;
    if (ready && !err) begin
      unique case (1'b1)
        is_byte: rdata_c = {{24{bus.load_signed & byte_v[7]}}, byte_v};
        is_half: rdata_c = {{16{bus.load_signed & half_v[15]}}, half_v};
        default: rdata_c = rd_word;
      endcase
    end
  end

  assign commit = ready & bus.mem_write & ~err & ~reset;

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (commit) begin
      mem_q[idx] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (commit) begin
      $display("%d@%h: *%h <= %h", $time, bus.pc,
               {bus.addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

  assign bus.rdata    = rdata_c;
  assign bus.busy     = ~ready;
  assign bus.addr_err = err;

endmodule

// File: tb/tb_dm_store_unit.sv
// Directed bench for dm_store_unit (DEPTH=16).
// Hand-computed expectations for clear, lane merge, extension, errors.
module tb_dm_store_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  dm_store_unit_if bus ();

  dm_store_unit #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [1:0] s,
                     input logic sg, input logic we,
                     input logic [31:0] wd);
    bus.addr        = a;
    bus.size        = s;
    bus.load_signed = sg;
    bus.mem_write   = we;
    bus.wdata       = wd;
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  int n;

  initial begin
    reset = 1'b1;
    bus.pc = 32'h0000_1000;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_write = 1'b0;
    bus.size = W;
    bus.load_signed = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("busy_after_reset", 32'(bus.busy), 32'd1);

    drv(32'h6, W, 0, 0, 0);
    check("clear_err", 32'(bus.addr_err), 32'd0);
    check("clear_rdata", bus.rdata, 32'd0);
    drv(32'h0, W, 0, 1, 32'h1234_5678);
    count_busy(n);
    bus.mem_write = 1'b0;
    check("clear_cycles", 32'(n), 32'd16);
    check("busy_low", 32'(bus.busy), 32'd0);

    drv(32'h0, W, 0, 0, 0);
    check("store_in_clear", bus.rdata, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drv(32'(i * 4), W, 0, 0, 0);
      check("zero_word", bus.rdata, 32'd0);
    end

    tick();
    drv(32'hC, W, 0, 1, 32'hFFFF_FFFF);
    tick();
    drv(32'hC, W, 0, 0, 0);
    check("preload", bus.rdata, 32'hFFFF_FFFF);

    drv(32'h10, W, 0, 1, 32'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    check("busy_reset2", 32'(bus.busy), 32'd1);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    count_busy(n);
    check("midclear_cycles", 32'(n), 32'd16);
    drv(32'hC, W, 0, 0, 0);
    check("preload_cleared", bus.rdata, 32'd0);
    drv(32'h10, W, 0, 0, 0);
    check("reset_store_drop", bus.rdata, 32'd0);

    drv(32'h8, W, 0, 1, 32'h1122_3344);
    tick();
    drv(32'h9, B, 0, 1, 32'h0000_00AA);
    tick();
    drv(32'hA, H, 0, 1, 32'h0000_BEEF);
    tick();
    bus.mem_write = 1'b0;
    drv(32'h8, W, 1, 0, 0);
    check("lw_merged", bus.rdata, 32'hBEEF_AA44);
    drv(32'h9, B, 1, 0, 0);
    check("lb_9", bus.rdata, 32'hFFFF_FFAA);
    drv(32'h9, B, 0, 0, 0);
    check("lbu_9", bus.rdata, 32'h0000_00AA);
    drv(32'hA, H, 1, 0, 0);
    check("lh_A", bus.rdata, 32'hFFFF_BEEF);
    drv(32'hA, H, 0, 0, 0);
    check("lhu_A", bus.rdata, 32'h0000_BEEF);
    drv(32'h8, B, 1, 0, 0);
    check("lb_8", bus.rdata, 32'h0000_0044);
    drv(32'hB, B, 1, 0, 0);
    check("lb_B", bus.rdata, 32'hFFFF_FFBE);
    drv(32'h8, H, 1, 0, 0);
    check("lh_8", bus.rdata, 32'hFFFF_AA44);

    drv(32'h6, W, 0, 1, 32'hDEAD_BEEF);
    check("sw6_err", 32'(bus.addr_err), 32'd1);
    check("sw6_rdata", bus.rdata, 32'd0);
    tick();
    bus.mem_write = 1'b0;
    drv(32'h4, W, 0, 0, 0);
    check("word1_kept", bus.rdata, 32'd0);
    check("aligned_ok", 32'(bus.addr_err), 32'd0);
    drv(32'h5, H, 0, 0, 0);
    check("sh5_err", 32'(bus.addr_err), 32'd1);
    drv(32'h7, B, 0, 0, 0);
    check("sb7_ok", 32'(bus.addr_err), 32'd0);
    drv(32'h3C, W, 0, 0, 0);
    check("last_word_ok", 32'(bus.addr_err), 32'd0);
    drv(32'h8000_0000, W, 0, 0, 0);
    check("hi_bit_err", 32'(bus.addr_err), 32'd1);
    drv(32'h40, W, 0, 1, 32'h7777_7777);
    check("oor_err", 32'(bus.addr_err), 32'd1);
    tick();
    bus.mem_write = 1'b0;
    drv(32'h0, W, 0, 0, 0);
    check("oor_no_alias", bus.rdata, 32'd0);

    drv(32'h10, 2'b11, 0, 1, 32'h0102_0304);
    tick();
    bus.mem_write = 1'b0;
    drv(32'h11, B, 0, 0, 0);
    check("size11_store", bus.rdata, 32'h0000_0003);
    drv(32'h12, 2'b11, 0, 0, 0);
    check("size11_err", 32'(bus.addr_err), 32'd1);

    bus.pc = 32'h0000_2000;
    drv(32'h4, W, 0, 1, 32'hCAFE_BABE);
    check("rdw_old", bus.rdata, 32'd0);
    tick();
    bus.mem_write = 1'b0;
    #1;
    check("rdw_new", bus.rdata, 32'hCAFE_BABE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
